// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N:1 arbitrated mux with registered output.
package arb_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  // Widest one-hot vector onehot_to_idx accepts; callers zero-extend.
  localparam int MAX_IN = 64;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [MAX_IN-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_IN - 1; i >= 0; i--) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: scans ptr+1, ptr+2, ... modulo NUM_IN.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  logic found;

  // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_IN]) begin
        grant[(int'(ptr) + k) % NUM_IN] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign grant_idx = SEL_W'(onehot_to_idx(MAX_IN'(grant)));
  assign any_grant = |grant;

endmodule

// File: rtl/arb_mux_nx1.sv
// N:1 data selector with valid/ready handshake, fixed or round-robin selection,
// and a single-entry output register that drains and reloads in the same cycle.
module arb_mux_nx1
  import arb_mux_pkg::*;
#(
  parameter int  WIDTH  = 32,
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  arb_mode_e         mode_e;
  logic [NUM_IN-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              have_grant;
  logic              can_load;
  logic              xfer;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  assign mode_e = arb_mode_e'(mode);

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  // Fixed mode grants the selected channel whether or not it is valid, so
  // in_ready never depends on other channels; out-of-range sel falls back to 0.
  always_comb begin
    grant      = NUM_IN'(1);
    grant_idx  = '0;
    have_grant = 1'b1;
    if (mode_e == MODE_RR) begin
      grant      = rr_grant;
      grant_idx  = rr_idx;
      have_grant = rr_any;
    end else if (int'(sel) < NUM_IN) begin
      grant     = NUM_IN'(1) << sel;
      grant_idx = sel;
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign in_ready = (!rst && can_load && have_grant) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_d   = grant_idx;
      if (mode_e == MODE_RR) rr_ptr_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
